apb_reg_bridge: RTL and testbench

APB3/APB4 slave front-end that turns bus transfers into the single-cycle register-port strobes used by peripheral register blocks such as the GPIO data/direction block. It sits directly upstream of that block: it drives wr_ena/wr_addr/wr_byte_sel/wr_data and rd_ena/rd_addr, and returns the block's registered rd_data on PRDATA. It inserts wait states to cover the block's one-cycle read latency and flags illegal addresses with PSLVERR.

---
 rtl/apb_reg_bridge.sv | 160 ++++++++++++++++
 tb/tb_apb_reg_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_bridge.sv
// APB3/APB4 slave front-end producing single-cycle register-port strobes.
// Ports: sysclk_i/reset_n_i, APB slave (psel/penable/pwrite/paddr/pwdata/
// pstrb -> pready/prdata/pslverr), register port (wr_ena/wr_addr/
// wr_byte_sel/wr_data, rd_ena/rd_addr, rd_data_i one cycle after rd_ena).
module apb_reg_bridge #(
  parameter int PADDR_W    = 12,
  parameter int REG_ADDR_W = 4,
  parameter int NUM_REGS   = 2
) (
  input  logic                  sysclk_i,
  input  logic                  reset_n_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [PADDR_W-1:0]    paddr_i,
  input  logic [31:0]           pwdata_i,
  input  logic [3:0]            pstrb_i,
  output logic                  pready_o,
  output logic [31:0]           prdata_o,
  output logic                  pslverr_o,
  output logic                  wr_ena_o,
  output logic [REG_ADDR_W-1:0] wr_addr_o,
  output logic [3:0]            wr_byte_sel_o,
  output logic [31:0]           wr_data_o,
  output logic                  rd_ena_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  input  logic [31:0]           rd_data_i
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT,
    DONE
  } state_e;

  localparam int IW = REG_ADDR_W - 2;
  localparam logic [IW:0] NREGS = (IW+1)'(NUM_REGS);

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [31:0]           prdata_q, prdata_d;
  logic                  wr_ena_q, wr_ena_d;
  logic                  rd_ena_q, rd_ena_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]            bsel_q, bsel_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err;
  logic                  setup;

  // Out-of-window, misaligned or unimplemented word index.
  assign err = (|paddr_i[PADDR_W-1:REG_ADDR_W])
             | (|paddr_i[1:0])
             | ({1'b0, paddr_i[REG_ADDR_W-1:2]} >= NREGS);

  assign setup = psel_i & ~penable_i;

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    wr_ena_d  = 1'b0;
    rd_ena_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    bsel_d    = bsel_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          state_d   = ISSUE;
          write_d   = pwrite_i;
          err_d     = err;
          wr_addr_d = paddr_i[REG_ADDR_W-1:0];
          rd_addr_d = paddr_i[REG_ADDR_W-1:0];
          wdata_d   = pwdata_i;
          if (pwrite_i) bsel_d = pstrb_i;
          wr_ena_d  = pwrite_i & ~err & (|pstrb_i);
          rd_ena_d  = ~pwrite_i & ~err;
        end
      end
      ISSUE: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else if (write_q || err_q) begin
          state_d   = DONE;
          pready_d  = 1'b1;
          pslverr_d = err_q;
          // Illegal reads return zero.
          if (!write_q) prdata_d = '0;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else begin
          state_d  = DONE;
          pready_d = 1'b1;
          prdata_d = rd_data_i;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      wr_ena_q  <= 1'b0;
      rd_ena_q  <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      bsel_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      wr_ena_q  <= wr_ena_d;
      rd_ena_q  <= rd_ena_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      bsel_q    <= bsel_d;
      wdata_q   <= wdata_d;
    end
  end

  assign pready_o      = pready_q;
  assign pslverr_o     = pslverr_q;
  assign prdata_o      = prdata_q;
  assign wr_ena_o      = wr_ena_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_byte_sel_o = bsel_q;
  assign wr_data_o     = wdata_q;
  assign rd_ena_o      = rd_ena_q;
  assign rd_addr_o     = rd_addr_q;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Bench for apb_reg_bridge: transaction-level model, per-cycle compare.
// Register block model answers rd_ena with registered data.
module tb_apb_reg_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready_o;
  logic [31:0] prdata_o;
  logic        pslverr_o;
  logic        wr_ena_o;
  logic [3:0]  wr_addr_o;
  logic [3:0]  wr_byte_sel_o;
  logic [31:0] wr_data_o;
  logic        rd_ena_o;
  logic [3:0]  rd_addr_o;
  logic [31:0] rd_data = '0;

  apb_reg_bridge #(
    .PADDR_W(12),
    .REG_ADDR_W(4),
    .NUM_REGS(2)
  ) dut (
    .sysclk_i(clk),
    .reset_n_i(reset_n),
    .psel_i(psel),
    .penable_i(penable),
    .pwrite_i(pwrite),
    .paddr_i(paddr),
    .pwdata_i(pwdata),
    .pstrb_i(pstrb),
    .pready_o(pready_o),
    .prdata_o(prdata_o),
    .pslverr_o(pslverr_o),
    .wr_ena_o(wr_ena_o),
    .wr_addr_o(wr_addr_o),
    .wr_byte_sel_o(wr_byte_sel_o),
    .wr_data_o(wr_data_o),
    .rd_ena_o(rd_ena_o),
    .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data)
  );

  always #5 clk = ~clk;

  // Downstream register block: byte-merged writes, registered reads.
  logic [31:0] mem [4] = '{default: 32'h0};
  always @(posedge clk) begin
    if (wr_ena_o)
      for (int b = 0; b < 4; b++)
        if (wr_byte_sel_o[b])
          mem[wr_addr_o[3:2]][8*b +: 8] <= wr_data_o[8*b +: 8];
    if (rd_ena_o) rd_data <= mem[rd_addr_o[3:2]];
  end

  // Transaction-level shadow and expected outputs.
  logic [31:0] shadow [4] = '{default: 32'h0};
  logic        e_pready = 0, e_pslverr = 0;
  logic        e_wr_ena = 0, e_rd_ena = 0;
  logic [31:0] e_prdata = 0, e_wdata = 0;
  logic [3:0]  e_waddr = 0, e_raddr = 0, e_bsel = 0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%h required=%h", n, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("pready", 32'(pready_o), 32'(e_pready));
    chk("pslverr", 32'(pslverr_o), 32'(e_pslverr));
    chk("prdata", prdata_o, e_prdata);
    chk("wr_ena", 32'(wr_ena_o), 32'(e_wr_ena));
    chk("rd_ena", 32'(rd_ena_o), 32'(e_rd_ena));
    chk("wr_addr", 32'(wr_addr_o), 32'(e_waddr));
    chk("rd_addr", 32'(rd_addr_o), 32'(e_raddr));
    chk("wr_data", wr_data_o, e_wdata);
    chk("wr_bsel", 32'(wr_byte_sel_o), 32'(e_bsel));
  end

  function automatic logic is_err(input logic [11:0] a);
    return (a[11:4] != 0) || (a[1:0] != 0) || (a[3:2] >= 2'd2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    e_pready  = 0;
    e_pslverr = 0;
    e_wr_ena  = 0;
    e_rd_ena  = 0;
  endtask

  task automatic exp_zero();
    exp_idle();
    e_prdata = 0;
    e_wdata  = 0;
    e_waddr  = 0;
    e_raddr  = 0;
    e_bsel   = 0;
  endtask

  // abort: 0 none, 1 drop psel in ISSUE, 2 drop psel in RDWAIT,
  // 3 assert reset in RDWAIT.
  task automatic xfer(input logic w, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input int abort);
    logic err;
    int   idx;
    err = is_err(a);
    idx = int'(a[3:2]);
    psel = 1; penable = 0; pwrite = w;
    paddr = a; pwdata = d; pstrb = s;
    tick();
    exp_idle();
    e_waddr  = a[3:0];
    e_raddr  = a[3:0];
    e_wdata  = d;
    if (w) e_bsel = s;
    e_wr_ena = w && !err && (s != 0);
    e_rd_ena = !w && !err;
    if (w && !err)
      for (int b = 0; b < 4; b++)
        if (s[b]) shadow[idx][8*b +: 8] = d[8*b +: 8];
    penable = 1;
    if (abort == 1) begin
      psel = 0; penable = 0;
      tick();
      exp_idle();
      return;
    end
    tick();
    exp_idle();
    if (w || err) begin
      e_pready  = 1;
      e_pslverr = err;
      if (!w) e_prdata = 0;
    end else begin
      if (abort == 2) begin
        psel = 0; penable = 0;
        tick();
        exp_idle();
        return;
      end
      if (abort == 3) begin
        reset_n = 0;
        #1;
        chk("lit_rst_prdata", prdata_o, 32'h0);
        chk("lit_rst_wraddr", 32'(wr_addr_o), 32'h0);
        exp_zero();
        psel = 0; penable = 0;
        tick();
        reset_n = 1;
        tick();
        return;
      end
      tick();
      exp_idle();
      e_pready = 1;
      e_prdata = shadow[idx];
    end
    tick();
    exp_idle();
    psel = 0; penable = 0;
  endtask

  // Idle cycles, sometimes with a stray penable that must be ignored.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        psel = 1; penable = 1;
      end else begin
        psel = 0; penable = 0;
      end
      pwrite = 1'($urandom_range(0, 1));
      tick();
      exp_idle();
    end
    psel = 0; penable = 0;
  endtask

  initial begin
    logic        w;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          ab;
    int          r;
    repeat (2) tick();
    reset_n = 1;
    tick();

    xfer(1, 12'h000, 32'h0000_00A5, 4'b0001, 0);
    chk("lit_wdata", wr_data_o, 32'h0000_00A5);
    chk("lit_bsel", 32'(wr_byte_sel_o), 32'h1);
    idle(1);
    xfer(1, 12'h004, 32'h0000_0003, 4'hF, 0);
    idle(1);
    xfer(0, 12'h004, 32'h0, 4'h0, 0);
    chk("lit_rd4", prdata_o, 32'h0000_0003);
    xfer(0, 12'h008, 32'h0, 4'hF, 0);
    chk("lit_err_rd", prdata_o, 32'h0);
    xfer(1, 12'h002, 32'hFFFF_FFFF, 4'hF, 0);
    idle(2);

    xfer(1, 12'h004, 32'h1, 4'hF, 0);
    xfer(0, 12'h004, 32'h0, 4'h0, 0);
    chk("lit_b2b_rd", prdata_o, 32'h1);
    xfer(1, 12'h000, 32'h0, 4'hF, 0);
    idle(1);

    xfer(0, 12'h000, 32'h0, 4'h0, 3);
    xfer(1, 12'h000, 32'h1234_5678, 4'hF, 0);
    xfer(0, 12'h000, 32'h0, 4'h0, 0);
    chk("lit_after_rst", prdata_o, 32'h1234_5678);
    xfer(1, 12'h004, 32'hDEAD_BEEF, 4'hF, 0);
    xfer(0, 12'h004, 32'h0, 4'h0, 1);
    chk("lit_abort_prdata", prdata_o, 32'h1234_5678);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 9));
      if (r <= 5)
        a = {8'h0, 2'($urandom_range(0, 1)), 2'b00};
      else if (r == 6)
        a = {8'h0, 2'($urandom_range(2, 3)), 2'b00};
      else if (r == 7)
        a = {8'h0, 2'($urandom_range(0, 1)), 2'($urandom_range(1, 3))};
      else if (r == 8)
        a = {8'($urandom_range(1, 255)), 4'h0};
      else
        a = 12'($urandom);
      r = int'($urandom_range(0, 19));
      ab = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      xfer(w, a, d, s, ab);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
